// File: rtl/t_pulse_pkg.sv
// rtl/t_pulse_pkg.sv - shared types and defaults for the pushbutton pulse debouncer
package t_pulse_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      CHK_PRESS   = 2'd1,
      PRESSED     = 2'd2,
      CHK_RELEASE = 2'd3
   } debounce_state_t;

   localparam int DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous level
module sync_2ff (
   input  logic clk,
   input  logic clr,
   input  logic d,
   output logic q
);

   logic s1;

   // Shift the raw level through two flops; only q is safe to use downstream
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         s1 <= 1'b0;
         q  <= 1'b0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/t_pulse_debouncer.sv
// rtl/t_pulse_debouncer.sv - debounces a raw button and emits one toggle pulse per press
module t_pulse_debouncer
   import t_pulse_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic clr,
   input  logic btn_in,
   output logic t,
   output logic stable,
   output logic busy
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   generate
      if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
         $error("t_pulse_debouncer: DEBOUNCE_CYCLES must be at least 1");
      end
   endgenerate

   logic            s2;
   debounce_state_t state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic            t_n, stable_n;

   sync_2ff u_sync (
      .clk (clk),
      .clr (clr),
      .d   (btn_in),
      .q   (s2)
   );

   // State, counter and output registers; clear discards any pending validation
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state  <= IDLE;
         cnt    <= '0;
         t      <= 1'b0;
         stable <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         t      <= t_n;
         stable <= stable_n;
      end
   end

   // Next-state logic: the counter only advances while the synchronized level holds
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      t_n      = 1'b0;
      stable_n = stable;
      case (state)
         IDLE: begin
            if (s2) begin
               state_n = CHK_PRESS;
               cnt_n   = '0;
            end
         end
         CHK_PRESS: begin
            if (!s2) begin
               state_n = IDLE;
            end else if (cnt == CNT_LAST) begin
               state_n  = PRESSED;
               t_n      = 1'b1;
               stable_n = 1'b1;
            end else begin
               cnt_n = cnt + CNT_ONE;
            end
         end
         PRESSED: begin
            if (!s2) begin
               state_n = CHK_RELEASE;
               cnt_n   = '0;
            end
         end
         CHK_RELEASE: begin
            if (s2) begin
               state_n = PRESSED;
            end else if (cnt == CNT_LAST) begin
               state_n  = IDLE;
               stable_n = 1'b0;
            end else begin
               cnt_n = cnt + CNT_ONE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign busy = (state == CHK_PRESS) || (state == CHK_RELEASE);

endmodule

// File: tb/tb_t_pulse_debouncer.sv
// tb/tb_t_pulse_debouncer.sv - self-checking bench for the pulse debouncer
module tb_t_pulse_debouncer;

   logic clk = 1'b0;
   logic clr;
   logic btn, btn1;
   logic t4, st4, bz4;
   logic t1, st1, bz1;
   logic q;

   int checks   = 0;
   int failures = 0;
   int pulses4  = 0;
   int pulses1  = 0;

   always #5 clk = ~clk;

   t_pulse_debouncer #(.DEBOUNCE_CYCLES(4)) u_dut4 (
      .clk    (clk),
      .clr    (clr),
      .btn_in (btn),
      .t      (t4),
      .stable (st4),
      .busy   (bz4)
   );

   t_pulse_debouncer #(.DEBOUNCE_CYCLES(1)) u_dut1 (
      .clk    (clk),
      .clr    (clr),
      .btn_in (btn1),
      .t      (t1),
      .stable (st1),
      .busy   (bz1)
   );

   // T flip-flop downstream of the debouncer
   always @(posedge clk or posedge clr) begin
      if (clr) q <= 1'b0;
      else if (t4) q <= ~q;
   end

   // Model: the accepted level flips once the synchronized level (btn two edges ago)
   // has differed from it on d+1 consecutive edges; a flip to 1 is a pulse.
   typedef struct {
      logic h1;
      logic h2;
      int   run;
      logic st;
      logic t;
   } mdl_t;

   mdl_t m4, m1;

   function automatic mdl_t mdl_step(mdl_t m, logic b, int d);
      mdl_t r = m;
      r.t = 1'b0;
      if (m.h2 != m.st) begin
         r.run = m.run + 1;
         if (r.run == d + 1) begin
            r.st  = m.h2;
            r.t   = m.h2;
            r.run = 0;
         end
      end else begin
         r.run = 0;
      end
      r.h2 = m.h1;
      r.h1 = b;
      return r;
   endfunction

   function automatic mdl_t mdl_reset();
      mdl_t r;
      r.h1 = 1'b0; r.h2 = 1'b0; r.run = 0; r.st = 1'b0; r.t = 1'b0;
      return r;
   endfunction

   initial begin
      m4 = mdl_reset();
      m1 = mdl_reset();
   end

   always @(posedge clk or posedge clr) begin
      if (clr) begin
         m4 = mdl_reset();
         m1 = mdl_reset();
      end else begin
         m4 = mdl_step(m4, btn, 4);
         m1 = mdl_step(m1, btn1, 1);
      end
   end

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
      end
   endtask

   task automatic chk_i(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      chk("model_t4", t4, m4.t);
      chk("model_stable4", st4, m4.st);
      chk("model_busy4", bz4, m4.run != 0);
      chk("model_t1", t1, m1.t);
      chk("model_stable1", st1, m1.st);
      chk("model_busy1", bz1, m1.run != 0);
      if (t4) pulses4++;
      if (t1) pulses1++;
   end

   task automatic press_literals(input string tag);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk({tag, "_t"}, t4, k == 6);
         chk({tag, "_stable"}, st4, k >= 6);
         chk({tag, "_busy"}, bz4, k >= 2 && k <= 5);
      end
   endtask

   int p0;
   logic [2:0] qexp;

   initial begin
      clr  = 1'b1;
      btn  = 1'b0;
      btn1 = 1'b0;
      qexp = 3'b101;
      repeat (2) @(negedge clk);
      clr = 1'b0;
      chk("reset_t", t4, 1'b0);
      chk("reset_stable", st4, 1'b0);
      chk("reset_busy", bz4, 1'b0);
      repeat (3) @(negedge clk);

      // clean press, held
      p0  = pulses4;
      btn = 1'b1;
      press_literals("press");
      repeat (20) @(negedge clk);
      chk_i("press_pulses", pulses4 - p0, 1);
      btn = 1'b0;
      repeat (12) @(negedge clk);
      chk("release_stable", st4, 1'b0);

      // press bounce rejected
      p0  = pulses4;
      btn = 1'b1; repeat (2) @(negedge clk);
      btn = 1'b0; repeat (1) @(negedge clk);
      btn = 1'b1; repeat (2) @(negedge clk);
      btn = 1'b0; repeat (12) @(negedge clk);
      chk_i("bounce_pulses", pulses4 - p0, 0);
      chk("bounce_stable", st4, 1'b0);
      chk("bounce_busy", bz4, 1'b0);

      // release bounce rejected, then clean release
      btn = 1'b1; repeat (12) @(negedge clk);
      chk("held_stable", st4, 1'b1);
      p0  = pulses4;
      btn = 1'b0; repeat (2) @(negedge clk);
      btn = 1'b1; repeat (12) @(negedge clk);
      chk("relbounce_stable", st4, 1'b1);
      chk("relbounce_busy", bz4, 1'b0);
      btn = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("release_t", t4, 1'b0);
         chk("release_stable_k", st4, k < 6);
         chk("release_busy_k", bz4, k >= 2 && k <= 5);
      end
      chk_i("release_pulses", pulses4 - p0, 0);
      repeat (5) @(negedge clk);

      // clear in the middle of press validation
      btn = 1'b1;
      repeat (5) @(negedge clk);
      chk("midval_busy", bz4, 1'b1);
      #3 clr = 1'b1;
      #1;
      chk("clr_t", t4, 1'b0);
      chk("clr_stable", st4, 1'b0);
      chk("clr_busy", bz4, 1'b0);
      repeat (2) @(negedge clk);
      clr = 1'b0;
      press_literals("restart");
      btn = 1'b0;
      repeat (12) @(negedge clk);

      // system check with the T flip-flop
      clr = 1'b1;
      repeat (2) @(negedge clk);
      clr = 1'b0;
      chk("tff_reset_q", q, 1'b0);
      for (int i = 0; i < 3; i++) begin
         btn = 1'b1; repeat (10) @(negedge clk);
         btn = 1'b0; repeat (10) @(negedge clk);
         chk("tff_q", q, qexp[i]);
      end

      // single-cycle debounce instance
      p0   = pulses1;
      btn1 = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("d1_t", t1, k == 3);
         chk("d1_stable", st1, k >= 3);
         chk("d1_busy", bz1, k == 2);
      end
      repeat (10) @(negedge clk);
      chk_i("d1_pulses", pulses1 - p0, 1);
      btn1 = 1'b0;
      repeat (6) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
